// File: rtl/enemy_motion.sv
// enemy_motion
// Per-frame behaviour of one chasing enemy sprite. The enemy spawns at a
// fixed point and then chases the player. On a move frame it takes one STEP
// toward the player on each axis, and its position is clamped to the
// playfield. A bullet hit costs one point of health and freezes the enemy in
// HURT for a while; the last point of health sends it to DEAD, and it
// respawns when the DEAD timer runs out.
//
// Ports
//   frame_clk                  sole clock, one rising edge per video frame
//   Reset                      synchronous, active-low
//   Enable                     1 = game running, 0 = hold every register
//   Player_X, Player_Y         player position (unsigned pixels)
//   Hit                        bullet hit on this enemy during this frame
//   Obj_X_Pos, Obj_Y_Pos       enemy position (registered)
//   Obj_X_Motion, Obj_Y_Motion two's-complement delta requested this frame
//   Obj_Dir                    facing: 0 up, 1 down, 2 left, 3 right
//   Alive                      1 while chasing or hurt
//   Touch_Player               registered contact flag
module enemy_motion #(
  parameter int         STEP           = 1,
  parameter int         MOVE_DIV       = 2,
  parameter logic [8:0] SPAWN_X        = 9'd16,
  parameter logic [8:0] SPAWN_Y        = 9'd16,
  parameter logic [8:0] X_MAX          = 9'd303,
  parameter logic [8:0] Y_MAX          = 9'd223,
  parameter int         HEALTH         = 3,
  parameter int         HURT_FRAMES    = 8,
  parameter int         RESPAWN_FRAMES = 60,
  parameter int         TOUCH_DIST     = 12
) (
  input  logic       frame_clk,
  input  logic       Reset,
  input  logic       Enable,
  input  logic [8:0] Player_X,
  input  logic [8:0] Player_Y,
  input  logic       Hit,
  output logic [8:0] Obj_X_Pos,
  output logic [8:0] Obj_Y_Pos,
  output logic [8:0] Obj_X_Motion,
  output logic [8:0] Obj_Y_Motion,
  output logic [1:0] Obj_Dir,
  output logic       Alive,
  output logic       Touch_Player
);

  localparam int TMAX = (HURT_FRAMES > RESPAWN_FRAMES) ? HURT_FRAMES : RESPAWN_FRAMES;
  localparam int TW   = $clog2(TMAX + 1);

  localparam logic signed [9:0] STEP_S      = 10'(STEP);
  localparam logic [3:0]        MOVE_LAST   = 4'(MOVE_DIV - 1);
  localparam logic [2:0]        HEALTH_INIT = 3'(HEALTH);
  localparam logic [TW-1:0]     HURT_LAST   = TW'(HURT_FRAMES - 1);
  localparam logic [TW-1:0]     DEAD_LAST   = TW'(RESPAWN_FRAMES - 1);
  localparam logic [8:0]        TOUCH_L     = 9'(TOUCH_DIST);

  typedef enum logic [1:0] {
    S_SPAWN = 2'd0,
    S_CHASE = 2'd1,
    S_HURT  = 2'd2,
    S_DEAD  = 2'd3
  } state_t;

  state_t        state_q, state_d;
  logic [8:0]    x_q, x_d, y_q, y_d;
  logic [8:0]    mx_q, mx_d, my_q, my_d;
  logic [1:0]    dir_q, dir_d;
  logic [2:0]    health_q, health_d;
  logic [3:0]    mcnt_q, mcnt_d;
  logic [TW-1:0] tmr_q, tmr_d;
  logic          touch_q, touch_d;

  // Step request toward the target: +STEP, -STEP or 0 (dead zone |d| < STEP).
  function automatic logic signed [9:0] step_toward(input logic [8:0] tgt,
                                                    input logic [8:0] pos);
    logic signed [9:0] d;
    d = $signed({1'b0, tgt}) - $signed({1'b0, pos});
    if (d >= STEP_S)       return STEP_S;
    else if (d <= -STEP_S) return -STEP_S;
    else                   return 10'sd0;
  endfunction

  // pos + m, saturated to [0, maxv]. The 11-bit sum cannot wrap, so its top
  // bit is a reliable sign.
  function automatic logic [8:0] clamp_pos(input logic [8:0]        pos,
                                           input logic signed [9:0] m,
                                           input logic [8:0]        maxv);
    logic [10:0] sum;
    sum = {2'b00, pos} + {m[9], m};
    if (sum[10])                     return 9'd0;
    else if (sum[9:0] > {1'b0, maxv}) return maxv;
    else                             return sum[8:0];
  endfunction

  function automatic logic [8:0] abs_diff(input logic [8:0] a, input logic [8:0] b);
    return (a >= b) ? (a - b) : (b - a);
  endfunction

  // State register
  always_ff @(posedge frame_clk) begin
    if (!Reset)      state_q <= S_SPAWN;
    else if (Enable) state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_SPAWN: state_d = S_CHASE;
      S_CHASE: if (Hit) state_d = (health_q == 3'd1) ? S_DEAD : S_HURT;
      S_HURT:  if (tmr_q == HURT_LAST) state_d = S_CHASE;
      S_DEAD:  if (tmr_q == DEAD_LAST) state_d = S_SPAWN;
      default: state_d = S_SPAWN;
    endcase
  end

  // Outputs
  always_comb begin
    Alive        = (state_q == S_CHASE) || (state_q == S_HURT);
    Obj_X_Pos    = x_q;
    Obj_Y_Pos    = y_q;
    Obj_X_Motion = mx_q;
    Obj_Y_Motion = my_q;
    Obj_Dir      = dir_q;
    Touch_Player = touch_q;
  end

  // Datapath next values
  logic signed [9:0] mxs, mys, amx, amy;
  logic              near, alive_next;

  always_comb begin
    mxs = step_toward(Player_X, x_q);
    mys = step_toward(Player_Y, y_q);
    amx = mxs[9] ? -mxs : mxs;
    amy = mys[9] ? -mys : mys;

    near       = (abs_diff(Player_X, x_q) < TOUCH_L) && (abs_diff(Player_Y, y_q) < TOUCH_L);
    alive_next = (state_d == S_CHASE) || (state_d == S_HURT);

    x_d      = x_q;
    y_d      = y_q;
    mx_d     = 9'd0;
    my_d     = 9'd0;
    dir_d    = dir_q;
    health_d = health_q;
    mcnt_d   = mcnt_q;
    tmr_d    = tmr_q;
    // Contact uses the position before this frame's update; an enemy that is
    // leaving the living states this frame never reports contact.
    touch_d  = Alive && alive_next && near;

    case (state_q)
      S_SPAWN: begin
        x_d      = SPAWN_X;
        y_d      = SPAWN_Y;
        health_d = HEALTH_INIT;
        mcnt_d   = 4'd0;
        tmr_d    = '0;
      end
      S_CHASE: begin
        if (Hit) begin
          health_d = health_q - 3'd1;
          tmr_d    = '0;
        end else begin
          mcnt_d = (mcnt_q == MOVE_LAST) ? 4'd0 : mcnt_q + 4'd1;
          if (mcnt_q == MOVE_LAST) begin
            mx_d = mxs[8:0];
            my_d = mys[8:0];
            x_d  = clamp_pos(x_q, mxs, X_MAX);
            y_d  = clamp_pos(y_q, mys, Y_MAX);
            // Facing follows the dominant axis; ties go horizontal.
            if ((mxs != 10'sd0) || (mys != 10'sd0)) begin
              if (amx >= amy) dir_d = mxs[9] ? 2'd2 : 2'd3;
              else            dir_d = mys[9] ? 2'd0 : 2'd1;
            end
          end
        end
      end
      S_HURT: begin
        if (tmr_q == HURT_LAST) begin
          tmr_d  = '0;
          mcnt_d = 4'd0;
        end else begin
          tmr_d = tmr_q + 1'b1;
        end
      end
      S_DEAD: begin
        tmr_d = (tmr_q == DEAD_LAST) ? '0 : tmr_q + 1'b1;
      end
      default: ;
    endcase
  end

  // Datapath registers
  always_ff @(posedge frame_clk) begin
    if (!Reset) begin
      x_q      <= SPAWN_X;
      y_q      <= SPAWN_Y;
      mx_q     <= 9'd0;
      my_q     <= 9'd0;
      dir_q    <= 2'd1;
      health_q <= HEALTH_INIT;
      mcnt_q   <= 4'd0;
      tmr_q    <= '0;
      touch_q  <= 1'b0;
    end else if (Enable) begin
      x_q      <= x_d;
      y_q      <= y_d;
      mx_q     <= mx_d;
      my_q     <= my_d;
      dir_q    <= dir_d;
      health_q <= health_d;
      mcnt_q   <= mcnt_d;
      tmr_q    <= tmr_d;
      touch_q  <= touch_d;
    end
  end

endmodule

// File: tb/tb_enemy_motion.sv
// Bench for enemy_motion. Two instances run in lockstep: the default
// configuration and a small-arena one (STEP=4, move every frame, spawn at the
// origin, X_MAX=6) for dead-zone and clamp cases. Each stimulus frame pushes
// the expected outputs for that edge; a monitor pops one record per frame and
// compares the fields marked as cared.
module tb_enemy_motion;

  logic       clk = 1'b0;
  logic       rst_n, en, hit, hit2;
  logic [8:0] px, py, p2x, p2y;

  logic [8:0] ox, oy, omx, omy;
  logic [1:0] odir;
  logic       oalive, otouch;
  logic [8:0] ox2, oy2, omx2, omy2;
  logic [1:0] odir2;
  logic       oalive2, otouch2;

  always #5 clk = ~clk;

  enemy_motion dut (
    .frame_clk(clk), .Reset(rst_n), .Enable(en),
    .Player_X(px), .Player_Y(py), .Hit(hit),
    .Obj_X_Pos(ox), .Obj_Y_Pos(oy), .Obj_X_Motion(omx), .Obj_Y_Motion(omy),
    .Obj_Dir(odir), .Alive(oalive), .Touch_Player(otouch)
  );

  enemy_motion #(
    .STEP(4), .MOVE_DIV(1), .SPAWN_X(9'd0), .SPAWN_Y(9'd0), .X_MAX(9'd6)
  ) dut2 (
    .frame_clk(clk), .Reset(rst_n), .Enable(en),
    .Player_X(p2x), .Player_Y(p2y), .Hit(hit2),
    .Obj_X_Pos(ox2), .Obj_Y_Pos(oy2), .Obj_X_Motion(omx2), .Obj_Y_Motion(omy2),
    .Obj_Dir(odir2), .Alive(oalive2), .Touch_Player(otouch2)
  );

  typedef struct {
    string      name;
    logic [11:0] care;
    logic [8:0] x, y, mx, my;
    logic [1:0] dir;
    logic       alive, touch;
    logic [8:0] x2, y2, mx2, my2;
    logic       touch2;
  } exp_t;

  localparam logic [11:0] ALL    = 12'h07F;
  localparam logic [11:0] NO_DIR = 12'h06F;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_pass   = 0;

  function automatic exp_t ex(input string n, input logic [11:0] care,
                              input logic [8:0] x, input logic [8:0] y,
                              input logic [8:0] mx, input logic [8:0] my,
                              input logic [1:0] dir, input logic al, input logic t);
    exp_t e;
    e.name = n; e.care = care;
    e.x = x; e.y = y; e.mx = mx; e.my = my; e.dir = dir; e.alive = al; e.touch = t;
    e.x2 = '0; e.y2 = '0; e.mx2 = '0; e.my2 = '0; e.touch2 = 1'b0;
    return e;
  endfunction

  function automatic exp_t with2(input exp_t e, input logic [8:0] x2, input logic [8:0] y2,
                                 input logic [8:0] mx2, input logic [8:0] my2, input logic t2);
    exp_t r;
    r = e;
    r.care = r.care | 12'hF80;
    r.x2 = x2; r.y2 = y2; r.mx2 = mx2; r.my2 = my2; r.touch2 = t2;
    return r;
  endfunction

  task automatic chk(input string n, input string f, input logic [8:0] act, input logic [8:0] want);
    n_checks++;
    if (act === want) n_pass++;
    else $display("FAIL %s.%s got %0d expected %0d", n, f, act, want);
  endtask

  // Monitor: one record per frame, sampled mid-cycle.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        if (e.care[0])  chk(e.name, "x",      ox,               e.x);
        if (e.care[1])  chk(e.name, "y",      oy,               e.y);
        if (e.care[2])  chk(e.name, "mx",     omx,              e.mx);
        if (e.care[3])  chk(e.name, "my",     omy,              e.my);
        if (e.care[4])  chk(e.name, "dir",    {7'd0, odir},     {7'd0, e.dir});
        if (e.care[5])  chk(e.name, "alive",  {8'd0, oalive},   {8'd0, e.alive});
        if (e.care[6])  chk(e.name, "touch",  {8'd0, otouch},   {8'd0, e.touch});
        if (e.care[7])  chk(e.name, "x2",     ox2,              e.x2);
        if (e.care[8])  chk(e.name, "y2",     oy2,              e.y2);
        if (e.care[9])  chk(e.name, "mx2",    omx2,             e.mx2);
        if (e.care[10]) chk(e.name, "my2",    omy2,             e.my2);
        if (e.care[11]) chk(e.name, "touch2", {8'd0, otouch2},  {8'd0, e.touch2});
      end
    end
  end

  task automatic step(input exp_t e);
    sb.push_back(e);
    @(posedge clk);
    #2;
  endtask

  // Small-arena player X per frame and its hand-derived results.
  logic [8:0] p2x_tab [10] = '{9'd0, 9'd0, 9'd0, 9'd0, 9'd0, 9'd2, 9'd7, 9'd20, 9'd5, 9'd0};
  logic [8:0] x2_tab  [10] = '{9'd0, 9'd0, 9'd0, 9'd0, 9'd0, 9'd0, 9'd4, 9'd6, 9'd6, 9'd2};
  logic [8:0] mx2_tab [10] = '{9'd0, 9'd0, 9'd0, 9'd0, 9'd0, 9'd0, 9'd4, 9'd4, 9'd0, 9'h1FC};
  logic       t2_tab  [10] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1};

  initial begin
    exp_t e;
    rst_n = 1'b0; en = 1'b1; hit = 1'b0; hit2 = 1'b0;
    px = 9'd100; py = 9'd16; p2x = 9'd0; p2y = 9'd0;

    // Reset values on both instances
    for (int i = 0; i < 2; i++)
      step(with2(ex("reset", ALL, 9'd16, 9'd16, 9'd0, 9'd0, 2'd1, 1'b0, 1'b0),
                 9'd0, 9'd0, 9'd0, 9'd0, 1'b0));
    rst_n = 1'b1;

    // Chase right: +1 on every second frame; small arena dead zone and clamp
    for (int k = 0; k < 10; k++) begin
      p2x = p2x_tab[k];
      if (k == 0) e = ex("spawn", ALL, 9'd16, 9'd16, 9'd0, 9'd0, 2'd1, 1'b1, 1'b0);
      else        e = ex("chase", ALL, 9'(16 + k / 2), 9'd16, (k % 2 == 0) ? 9'd1 : 9'd0, 9'd0,
                         (k >= 2) ? 2'd3 : 2'd1, 1'b1, 1'b0);
      step(with2(e, x2_tab[k], 9'd0, mx2_tab[k], 9'd0, t2_tab[k]));
    end

    // Player on top of the enemy, then at the touch-distance boundary
    px = 9'd20; py = 9'd16;
    step(ex("on_top_move", ALL, 9'd20, 9'd16, 9'd0, 9'd0, 2'd3, 1'b1, 1'b1));
    step(ex("on_top_idle", ALL, 9'd20, 9'd16, 9'd0, 9'd0, 2'd3, 1'b1, 1'b1));
    px = 9'd32;
    step(ex("touch_d12", ALL, 9'd21, 9'd16, 9'd1, 9'd0, 2'd3, 1'b1, 1'b0));
    step(ex("touch_d11", ALL, 9'd21, 9'd16, 9'd0, 9'd0, 2'd3, 1'b1, 1'b1));

    // Vertical chase, then a diagonal tie that must face horizontally
    px = 9'd21; py = 9'd100;
    step(ex("down_move", ALL, 9'd21, 9'd17, 9'd0, 9'd1, 2'd1, 1'b1, 1'b0));
    step(ex("down_idle", ALL, 9'd21, 9'd17, 9'd0, 9'd0, 2'd1, 1'b1, 1'b0));
    px = 9'd0; py = 9'd200;
    step(ex("diag_move", ALL, 9'd20, 9'd18, 9'h1FF, 9'd1, 2'd2, 1'b1, 1'b0));
    step(ex("diag_idle", ALL, 9'd20, 9'd18, 9'd0, 9'd0, 2'd2, 1'b1, 1'b0));

    // Enable low freezes everything, counters included, and ignores Hit
    en = 1'b0; hit = 1'b1;
    for (int i = 0; i < 3; i++)
      step(ex("freeze", ALL, 9'd20, 9'd18, 9'd0, 9'd0, 2'd2, 1'b1, 1'b0));
    en = 1'b1; hit = 1'b0;
    step(ex("unfreeze_move", ALL, 9'd19, 9'd19, 9'h1FF, 9'd1, 2'd2, 1'b1, 1'b0));

    // Hit held: hurt, hurt, dead; Hit during DEAD and SPAWN ignored;
    // then a hit on a move frame, then reset mid-HURT with Enable low
    for (int k = 0; k <= 83; k++) begin
      hit = (k <= 19) || (k >= 30 && k <= 40) || (k == 79) || (k == 81);
      if (k == 82) begin en = 1'b0; rst_n = 1'b0; end
      if (k == 83) begin en = 1'b1; rst_n = 1'b1; end
      if (k <= 17)      e = ex("hurt",     ALL,    9'd19, 9'd19, 9'd0, 9'd0, 2'd2, 1'b1, 1'b0);
      else if (k <= 78) e = ex("dead",     ALL,    9'd19, 9'd19, 9'd0, 9'd0, 2'd2, 1'b0, 1'b0);
      else if (k <= 81) e = ex("respawn",  NO_DIR, 9'd16, 9'd16, 9'd0, 9'd0, 2'd0, 1'b1, 1'b0);
      else if (k == 82) e = ex("rst_hurt", ALL,    9'd16, 9'd16, 9'd0, 9'd0, 2'd1, 1'b0, 1'b0);
      else              e = ex("spawn2",   ALL,    9'd16, 9'd16, 9'd0, 9'd0, 2'd1, 1'b1, 1'b0);
      step(e);
    end
    hit = 1'b0;

    for (int i = 0; i < 5 && sb.size() > 0; i++) begin
      @(negedge clk);
      #1;
    end
    n_checks++;
    if (sb.size() == 0) n_pass++;
    else $display("FAIL drain pending=%0d expected 0", sb.size());

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "timeout");
  end

endmodule
